// File: rtl/seg_disp_pkg.sv
// Shared constants and payload types for the multiplexed 7-segment display path.
package seg_disp_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned BCD_W      = 8;
    localparam int unsigned TGT_W      = 2;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;

    localparam logic [TGT_W-1:0] TGT_MS10 = 2'b00;
    localparam logic [TGT_W-1:0] TGT_SEC  = 2'b01;
    localparam logic [TGT_W-1:0] TGT_MIN  = 2'b10;
    localparam logic [TGT_W-1:0] TGT_RUN  = 2'b11;

    typedef struct packed {
        logic [BCD_W-1:0] min;
        logic [BCD_W-1:0] sec;
        logic [BCD_W-1:0] ms_10;
    } bcd_time_t;

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal nibbles show a dash.
module bcd7seg
    import seg_disp_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (nib)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Six-digit multiplexed common-anode display driver with per-frame snapshot,
// edit-field blink and whole-display flash on time-out.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic                  clk_core,
    input  logic                  rst,
    input  logic [BCD_W-1:0]      min_i,
    input  logic [BCD_W-1:0]      sec_i,
    input  logic [BCD_W-1:0]      ms_10_i,
    input  logic [TGT_W-1:0]      target,
    input  logic                  time_out,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IDX_W   = 3;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  BLANK_LIM  = SCAN_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_ph;
    logic [TGT_W-1:0]      tgt_q;
    bcd_time_t             snap;
    bcd_time_t             live;

    logic                  scan_wrap;
    logic [3:0]            nib;
    logic [SEG_W-1:0]      dec_seg;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_d;
    logic [SEG_W-1:0]      seg_d;
    logic                  dp_d;

    assign live      = '{min: min_i, sec: sec_i, ms_10: ms_10_i};
    assign scan_wrap = (scan_cnt == SCAN_LAST);

    // Digit select, blanking and output pattern for the current slot
    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        an_d  = {NUM_DIGITS{1'b1}};
        seg_d = SEG_OFF;
        dp_d  = 1'b1;

        case (idx)
            3'd0:    nib = snap.ms_10[3:0];
            3'd1:    nib = snap.ms_10[7:4];
            3'd2:    nib = snap.sec[3:0];
            3'd3:    nib = snap.sec[7:4];
            3'd4:    nib = snap.min[3:0];
            3'd5:    nib = snap.min[7:4];
            default: nib = 4'h0;
        endcase

        blank = (scan_cnt < BLANK_LIM)
              || (blink_ph && (target != TGT_RUN) && (idx[2:1] == target))
              || (blink_ph && time_out);

        if (!blank) begin
            an_d  = ~(NUM_DIGITS'(1) << idx);
            seg_d = dec_seg;
            dp_d  = !((idx == 3'd2) || (idx == 3'd4));
        end
    end

    bcd7seg u_bcd7seg (
        .nib   (nib),
        .seg_c (dec_seg)
    );

    always_ff @(posedge clk_core) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            tgt_q     <= target;
            snap      <= live;
            an        <= {NUM_DIGITS{1'b1}};
            seg       <= SEG_OFF;
            dp        <= 1'b1;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            // Frame-boundary snapshot keeps all six digits coherent
            if (scan_wrap && (idx == IDX_LAST)) begin
                snap <= live;
            end

            // A new edit field restarts the blink so it shows for a full half-period
            tgt_q <= target;
            if (target != tgt_q) begin
                blink_cnt <= '0;
                blink_ph  <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a short scan/blink period.
module tb_seg_scan_display;

    logic       clk_core = 1'b0;
    logic       rst;
    logic [7:0] min_i;
    logic [7:0] sec_i;
    logic [7:0] ms_10_i;
    logic [1:0] target;
    logic       time_out;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seg_scan_display #(
        .SCAN_DIV  (4),
        .BLANK_CYC (1),
        .BLINK_DIV (8)
    ) dut (
        .clk_core (clk_core),
        .rst      (rst),
        .min_i    (min_i),
        .sec_i    (sec_i),
        .ms_10_i  (ms_10_i),
        .target   (target),
        .time_out (time_out),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [5:0] a, input logic [6:0] s,
                              input logic d);
        chk({tag, ".an"},  {2'b00, an}, {2'b00, a});
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, s});
        chk({tag, ".dp"},  {7'b0, dp},  {7'b0, d});
    endtask

    task automatic check_blank(input string tag);
        check_disp(tag, 6'h3F, 7'h7F, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        rst      = 1'b1;
        min_i    = 8'h12;
        sec_i    = 8'h34;
        ms_10_i  = 8'h56;
        target   = 2'b11;
        time_out = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
        check_blank("reset");
        rst = 1'b0;
        cyc = 0;

        // Basic scan of 12:34.56 with target=running
        goto(1);   check_blank("s0_lead_blank");
        goto(2);   check_disp("s0_ms_u", 6'h3E, 7'h02, 1'b1);
        goto(5);   check_blank("s1_lead_blank");
        goto(6);   check_disp("s1_ms_t", 6'h3D, 7'h12, 1'b1);
        goto(10);  check_disp("s2_sec_u", 6'h3B, 7'h19, 1'b0);
        ms_10_i = 8'h99;
        goto(14);  check_disp("s3_sec_t", 6'h37, 7'h30, 1'b1);
        goto(18);  check_disp("s4_min_u", 6'h2F, 7'h24, 1'b0);
        goto(21);  check_blank("s5_lead_blank");
        goto(22);  check_disp("s5_min_t", 6'h1F, 7'h79, 1'b1);

        // Snapshot only refreshes at the frame boundary
        goto(26);  check_disp("f1_ms_u", 6'h3E, 7'h10, 1'b1);
        sec_i = 8'h78;
        goto(30);  check_disp("f1_ms_t", 6'h3D, 7'h10, 1'b1);
        goto(34);  check_disp("f1_sec_u_old", 6'h3B, 7'h19, 1'b0);
        goto(38);  check_disp("f1_sec_t_old", 6'h37, 7'h30, 1'b1);
        goto(58);  check_disp("f2_sec_u_new", 6'h3B, 7'h00, 1'b0);
        goto(62);  check_disp("f2_sec_t_new", 6'h37, 7'h78, 1'b1);

        // Seconds field blinks
        goto(72);  target = 2'b01;
        goto(82);  check_blank("sec_blink_u");
        goto(86);  check_blank("sec_blink_t");
        goto(98);  check_disp("ms_u_no_blink", 6'h3E, 7'h10, 1'b1);
        goto(102); check_disp("ms_t_no_blink", 6'h3D, 7'h10, 1'b1);
        goto(106); check_disp("sec_u_vis", 6'h3B, 7'h00, 1'b0);
        goto(110); check_disp("sec_t_vis", 6'h37, 7'h78, 1'b1);

        // Switch to minutes while in the blank phase: phase restarts visible
        goto(115); target = 2'b10;
        goto(118); check_disp("min_t_restart_vis", 6'h1F, 7'h79, 1'b1);
        goto(130); check_disp("sec_u_after_switch", 6'h3B, 7'h00, 1'b0);
        goto(138); check_disp("min_u_vis", 6'h2F, 7'h24, 1'b0);
        goto(142); check_blank("min_t_blink");

        // Time-out flashes the whole display
        goto(144); target = 2'b00; time_out = 1'b1;
        goto(146); check_disp("to_ms_u_vis", 6'h3E, 7'h10, 1'b1);
        goto(154); check_blank("to_sec_u_blank");
        goto(158); check_blank("to_sec_t_blank");
        goto(162); check_disp("to_min_u_vis", 6'h2F, 7'h24, 1'b0);
        goto(166); check_disp("to_min_t_vis", 6'h1F, 7'h79, 1'b1);
        goto(170); check_blank("to_ms_u_blank");
        goto(174); check_blank("to_ms_t_blank");
        goto(186); check_blank("to_min_u_blank");
        time_out = 1'b0;
        goto(187); check_disp("to_off_min_u", 6'h2F, 7'h24, 1'b0);
        goto(190); check_disp("to_off_min_t", 6'h1F, 7'h79, 1'b1);
        goto(202); check_disp("to_off_sec_u", 6'h3B, 7'h00, 1'b0);
        goto(218); check_blank("to_off_ms_u_blink");

        // Non-decimal nibble shows a dash
        sec_i = 8'hA7;
        goto(250); check_disp("hex_sec_u", 6'h3B, 7'h78, 1'b0);
        goto(254); check_disp("hex_sec_t", 6'h37, 7'h3F, 1'b1);

        // Reset mid-frame; snapshot follows inputs during reset
        goto(255);
        rst   = 1'b1;
        min_i = 8'h45;
        tick();
        check_blank("mid_reset");
        min_i = 8'h59;
        tick();
        rst = 1'b0;
        cyc = 0;
        goto(1);   check_blank("r_lead_blank");
        goto(2);   check_disp("r_ms_u", 6'h3E, 7'h10, 1'b1);
        goto(6);   check_disp("r_ms_t", 6'h3D, 7'h10, 1'b1);
        goto(10);  check_disp("r_sec_u", 6'h3B, 7'h78, 1'b0);
        goto(14);  check_disp("r_sec_t", 6'h37, 7'h3F, 1'b1);
        goto(18);  check_disp("r_min_u", 6'h2F, 7'h10, 1'b0);
        goto(22);  check_disp("r_min_t", 6'h1F, 7'h12, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
